// File: rtl/rv_decode_stage_pkg.sv
// Shared RV32I/RV64I definitions: opcode constants, instruction classes and the
// decoded-entry record carried through the decode stage.
package rv_decode_stage_pkg;

    localparam int XLEN_MAX = 64;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        IC_R       = 4'd0,
        IC_I_ALU   = 4'd1,
        IC_I_JALR  = 4'd2,
        IC_I_LOAD  = 4'd3,
        IC_J       = 4'd4,
        IC_S       = 4'd5,
        IC_B       = 4'd6,
        IC_U_LUI   = 4'd7,
        IC_U_AUIPC = 4'd8,
        IC_ILLEGAL = 4'd15
    } insn_class_t;

    // imm is held at the widest legal XLEN; narrower builds use the low bits.
    typedef struct packed {
        insn_class_t          itype;
        logic [4:0]           rd;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [2:0]           funct3;
        logic                 funct7b5;
        logic [XLEN_MAX-1:0]  imm;
    } decoded_t;

    function automatic insn_class_t classify_opcode(input logic [6:0] opc);
        case (opc)
            OPC_OP:     return IC_R;
            OPC_OP_IMM: return IC_I_ALU;
            OPC_JALR:   return IC_I_JALR;
            OPC_LOAD:   return IC_I_LOAD;
            OPC_JAL:    return IC_J;
            OPC_STORE:  return IC_S;
            OPC_BRANCH: return IC_B;
            OPC_LUI:    return IC_U_LUI;
            OPC_AUIPC:  return IC_U_AUIPC;
            default:    return IC_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/rv_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// o_illegal exists only when RV_DECODE_ILLEGAL_CHECK_EN is defined.
interface rv_decode_stage_if #(
    parameter int XLEN = 32
);
    import rv_decode_stage_pkg::*;

    logic              i_flush;
    logic              i_valid;
    logic              o_ready;
    logic [31:0]       i_instr;
    logic [XLEN-1:0]   i_pc;
    logic              o_valid;
    logic              i_ready;
    logic [XLEN-1:0]   o_pc;
    insn_class_t       o_itype;
    logic [4:0]        o_rd;
    logic [4:0]        o_rs1;
    logic [4:0]        o_rs2;
    logic [2:0]        o_funct3;
    logic              o_funct7b5;
    logic [XLEN-1:0]   o_imm;
`ifdef RV_DECODE_ILLEGAL_CHECK_EN
    logic              o_illegal;
`endif

    // Environment (fetch + execute) side.
    modport master (
        output i_flush, i_valid, i_instr, i_pc, i_ready,
        input  o_ready, o_valid, o_pc, o_itype, o_rd, o_rs1, o_rs2,
               o_funct3, o_funct7b5, o_imm
`ifdef RV_DECODE_ILLEGAL_CHECK_EN
        , input o_illegal
`endif
    );

    // Decode stage side.
    modport slave (
        input  i_flush, i_valid, i_instr, i_pc, i_ready,
        output o_ready, o_valid, o_pc, o_itype, o_rd, o_rs1, o_rs2,
               o_funct3, o_funct7b5, o_imm
`ifdef RV_DECODE_ILLEGAL_CHECK_EN
        , output o_illegal
`endif
    );

endinterface

// File: rtl/rv_imm_gen.sv
// Combinational RV32I/RV64I immediate generator, sign-extended to XLEN.
module rv_imm_gen
    import rv_decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    input  insn_class_t     itype_i,
    output logic [XLEN-1:0] imm_o
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (itype_i)
            IC_I_ALU, IC_I_JALR, IC_I_LOAD:
                imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            IC_S:
                imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IC_B:
                imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
            IC_U_LUI, IC_U_AUIPC:
                imm32 = {instr_i[31:12], 12'b0};
            IC_J:
                imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/rv_decode_stage.sv
// Registered decode stage with a main + skid entry pair so o_ready never
// depends combinationally on i_ready. Option: RV_DECODE_ILLEGAL_CHECK_EN.
module rv_decode_stage
    import rv_decode_stage_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    rv_decode_stage_if.slave   dec
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    decoded_t        main_q, main_d;
    decoded_t        skid_q, skid_d;
    logic [XLEN-1:0] main_pc_q, main_pc_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic            valid_q;
    logic            ready_q;

    insn_class_t         in_itype;
    logic [XLEN_MAX-1:0] in_imm;
    decoded_t            dec_in;
    logic                accept;
    logic                emit;

    always_comb begin
        in_itype = classify_opcode(dec.i_instr[6:0]);
`ifdef RV_DECODE_ILLEGAL_CHECK_EN
        if (dec.i_instr[1:0] != 2'b11)
            in_itype = IC_ILLEGAL;
        if (in_itype == IC_R && dec.i_instr[31:25] != 7'b0000000
                && dec.i_instr[31:25] != 7'b0100000)
            in_itype = IC_ILLEGAL;
        if (in_itype == IC_I_JALR && dec.i_instr[14:12] != 3'b000)
            in_itype = IC_ILLEGAL;
        if (in_itype == IC_I_LOAD && (dec.i_instr[14:12] == 3'b011
                || dec.i_instr[14:12] == 3'b110 || dec.i_instr[14:12] == 3'b111))
            in_itype = IC_ILLEGAL;
`endif
    end

    rv_imm_gen #(.XLEN(XLEN_MAX)) u_imm_gen (
        .instr_i (dec.i_instr),
        .itype_i (in_itype),
        .imm_o   (in_imm)
    );

    always_comb begin
        dec_in          = '0;
        dec_in.itype    = in_itype;
        dec_in.rd       = dec.i_instr[11:7];
        dec_in.rs1      = dec.i_instr[19:15];
        dec_in.rs2      = dec.i_instr[24:20];
        dec_in.funct3   = dec.i_instr[14:12];
        dec_in.funct7b5 = dec.i_instr[30];
        dec_in.imm      = in_imm;
    end

    assign accept = dec.i_valid && ready_q;
    assign emit   = valid_q && dec.i_ready;

    always_comb begin
        state_d   = state_q;
        main_d    = main_q;
        main_pc_d = main_pc_q;
        skid_d    = skid_q;
        skid_pc_d = skid_pc_q;
        if (dec.i_flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d   = ST_FULL;
                        main_d    = dec_in;
                        main_pc_d = dec.i_pc;
                    end
                end
                ST_FULL: begin
                    if (accept && !emit) begin
                        state_d   = ST_SKID;
                        skid_d    = dec_in;
                        skid_pc_d = dec.i_pc;
                    end else if (accept && emit) begin
                        main_d    = dec_in;
                        main_pc_d = dec.i_pc;
                    end else if (emit) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    // ready_q is low here, so only the drain into main can happen.
                    if (emit) begin
                        state_d   = ST_FULL;
                        main_d    = skid_q;
                        main_pc_d = skid_pc_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_EMPTY;
            main_q    <= '0;
            main_pc_q <= PC_RESET;
            skid_q    <= '0;
            skid_pc_q <= PC_RESET;
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            main_pc_q <= main_pc_d;
            skid_q    <= skid_d;
            skid_pc_q <= skid_pc_d;
            valid_q   <= (state_d != ST_EMPTY);
            ready_q   <= (state_d != ST_SKID);
        end
    end

    assign dec.o_valid    = valid_q;
    assign dec.o_ready    = ready_q;
    assign dec.o_pc       = main_pc_q;
    assign dec.o_itype    = main_q.itype;
    assign dec.o_rd       = main_q.rd;
    assign dec.o_rs1      = main_q.rs1;
    assign dec.o_rs2      = main_q.rs2;
    assign dec.o_funct3   = main_q.funct3;
    assign dec.o_funct7b5 = main_q.funct7b5;
    assign dec.o_imm      = main_q.imm[XLEN-1:0];
`ifdef RV_DECODE_ILLEGAL_CHECK_EN
    assign dec.o_illegal  = (main_q.itype == IC_ILLEGAL);
`endif

    generate
        if (XLEN < XLEN_MAX) begin : g_narrow
            logic unused_imm_hi;
            assign unused_imm_hi = ^main_q.imm[XLEN_MAX-1:XLEN];
        end
    endgenerate

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed self-checking bench for rv_decode_stage (XLEN=32, non-zero PC_RESET).
module tb_rv_decode_stage;
    import rv_decode_stage_pkg::*;

    localparam int          XLEN     = 32;
    localparam logic [31:0] PC_RST   = 32'h0000_0080;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    rv_decode_stage_if #(.XLEN(XLEN)) bus();

    rv_decode_stage #(.XLEN(XLEN), .PC_RESET(PC_RST)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .dec   (bus.slave)
    );

    task automatic drive_insn(input logic [31:0] instr, input logic [31:0] pc);
        bus.i_valid = 1'b1;
        bus.i_instr = instr;
        bus.i_pc    = pc;
        @(negedge clk);
        bus.i_valid = 1'b0;
        $display("txn accept instr=%h pc=%h -> itype=%0d imm=%h", instr, pc, bus.o_itype, bus.o_imm);
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.o_valid); end
        n_checks++;
        if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", bus.o_ready); end
        n_checks++;
        if (bus.o_pc !== PC_RST) begin n_fail++; $display("FAIL reset_pc got %h want %h", bus.o_pc, PC_RST); end
        n_checks++;
        if ({bus.o_itype, bus.o_rd, bus.o_rs1, bus.o_rs2, bus.o_funct3, bus.o_funct7b5, bus.o_imm} !== '0) begin
            n_fail++; $display("FAIL reset_fields got itype=%0d imm=%h want 0", bus.o_itype, bus.o_imm);
        end
        $display("txn reset valid=%b ready=%b pc=%h", bus.o_valid, bus.o_ready, bus.o_pc);
    endtask

    task automatic test_alu_imm();
        bus.i_ready = 1'b1;
        drive_insn(32'h0050_0093, 32'h0000_0100);
        n_checks++;
        if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid got %b want 1", bus.o_valid); end
        n_checks++;
        if (bus.o_itype !== IC_I_ALU) begin n_fail++; $display("FAIL addi_itype got %0d want 1", bus.o_itype); end
        n_checks++;
        if (bus.o_rd !== 5'd1 || bus.o_rs1 !== 5'd0) begin
            n_fail++; $display("FAIL addi_regs got rd=%0d rs1=%0d want rd=1 rs1=0", bus.o_rd, bus.o_rs1);
        end
        n_checks++;
        if (bus.o_imm !== 32'd5) begin n_fail++; $display("FAIL addi_imm got %h want 00000005", bus.o_imm); end
        n_checks++;
        if (bus.o_pc !== 32'h100) begin n_fail++; $display("FAIL addi_pc got %h want 00000100", bus.o_pc); end
        @(negedge clk);
        n_checks++;
        if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain got %b want 0", bus.o_valid); end
    endtask

    task automatic test_store();
        drive_insn(32'hFE20_AE23, 32'h0000_0104);
        n_checks++;
        if (bus.o_itype !== IC_S) begin n_fail++; $display("FAIL sw_itype got %0d want 5", bus.o_itype); end
        n_checks++;
        if (bus.o_rs1 !== 5'd1 || bus.o_rs2 !== 5'd2 || bus.o_funct3 !== 3'b010) begin
            n_fail++; $display("FAIL sw_fields got rs1=%0d rs2=%0d f3=%b want 1 2 010", bus.o_rs1, bus.o_rs2, bus.o_funct3);
        end
        n_checks++;
        if (bus.o_rd !== 5'd28 || bus.o_funct7b5 !== 1'b1) begin
            n_fail++; $display("FAIL sw_raw got rd=%0d f7b5=%b want 28 1", bus.o_rd, bus.o_funct7b5);
        end
        n_checks++;
        if (bus.o_imm !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL sw_imm got %h want fffffffc", bus.o_imm); end
        @(negedge clk);
    endtask

    task automatic test_branch_lui();
        drive_insn(32'hFE00_0CE3, 32'h0000_0108);
        n_checks++;
        if (bus.o_itype !== IC_B) begin n_fail++; $display("FAIL beq_itype got %0d want 6", bus.o_itype); end
        n_checks++;
        if (bus.o_imm !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL beq_imm got %h want fffffff8", bus.o_imm); end
        drive_insn(32'h1234_52B7, 32'h0000_010C);
        n_checks++;
        if (bus.o_itype !== IC_U_LUI || bus.o_rd !== 5'd5) begin
            n_fail++; $display("FAIL lui_class got itype=%0d rd=%0d want 7 5", bus.o_itype, bus.o_rd);
        end
        n_checks++;
        if (bus.o_imm !== 32'h1234_5000) begin n_fail++; $display("FAIL lui_imm got %h want 12345000", bus.o_imm); end
        drive_insn(32'h8000_006F, 32'h0000_0110);
        n_checks++;
        if (bus.o_itype !== IC_J || bus.o_imm !== 32'hFFF0_0000) begin
            n_fail++; $display("FAIL jal got itype=%0d imm=%h want 4 fff00000", bus.o_itype, bus.o_imm);
        end
        @(negedge clk);
    endtask

    task automatic test_illegal();
        drive_insn(32'h0000_007F, 32'h0000_0120);
        n_checks++;
        if (bus.o_itype !== IC_ILLEGAL || bus.o_imm !== 32'd0) begin
            n_fail++; $display("FAIL opc7f got itype=%0d imm=%h want 15 0", bus.o_itype, bus.o_imm);
        end
        drive_insn(32'h0050_0090, 32'h0000_0124);
        n_checks++;
        if (bus.o_itype !== IC_ILLEGAL) begin n_fail++; $display("FAIL lowbits got itype=%0d want 15", bus.o_itype); end
        drive_insn(32'h2000_0033, 32'h0000_0128);
`ifdef RV_DECODE_ILLEGAL_CHECK_EN
        n_checks++;
        if (bus.o_itype !== IC_ILLEGAL || bus.o_illegal !== 1'b1) begin
            n_fail++; $display("FAIL badf7 got itype=%0d ill=%b want 15 1", bus.o_itype, bus.o_illegal);
        end
        drive_insn(32'h0000_1067, 32'h0000_012C);
        n_checks++;
        if (bus.o_itype !== IC_ILLEGAL) begin n_fail++; $display("FAIL jalr_f3 got itype=%0d want 15", bus.o_itype); end
        drive_insn(32'h4000_0033, 32'h0000_0130);
        n_checks++;
        if (bus.o_itype !== IC_R || bus.o_illegal !== 1'b0) begin
            n_fail++; $display("FAIL sub got itype=%0d ill=%b want 0 0", bus.o_itype, bus.o_illegal);
        end
`else
        n_checks++;
        if (bus.o_itype !== IC_R || bus.o_imm !== 32'd0) begin
            n_fail++; $display("FAIL r_any_f7 got itype=%0d imm=%h want 0 0", bus.o_itype, bus.o_imm);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bus.i_ready = 1'b0;
        bus.i_valid = 1'b1; bus.i_instr = 32'h0010_0093; bus.i_pc = 32'h200;
        @(negedge clk);
        n_checks++;
        if (bus.o_valid !== 1'b1 || bus.o_pc !== 32'h200 || bus.o_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_a got v=%b pc=%h rdy=%b want 1 200 1", bus.o_valid, bus.o_pc, bus.o_ready);
        end
        bus.i_instr = 32'h0020_0093; bus.i_pc = 32'h204;
        @(negedge clk);
        n_checks++;
        if (bus.o_ready !== 1'b0 || bus.o_pc !== 32'h200 || bus.o_imm !== 32'd1) begin
            n_fail++; $display("FAIL b2b_skid got rdy=%b pc=%h imm=%h want 0 200 1", bus.o_ready, bus.o_pc, bus.o_imm);
        end
        bus.i_instr = 32'h0030_0093; bus.i_pc = 32'h208;
        @(negedge clk);
        n_checks++;
        if (bus.o_ready !== 1'b0 || bus.o_pc !== 32'h200 || bus.o_imm !== 32'd1) begin
            n_fail++; $display("FAIL b2b_hold got rdy=%b pc=%h imm=%h want 0 200 1", bus.o_ready, bus.o_pc, bus.o_imm);
        end
        $display("txn emit pc=%h imm=%h", bus.o_pc, bus.o_imm);
        bus.i_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.o_valid !== 1'b1 || bus.o_pc !== 32'h204 || bus.o_imm !== 32'd2 || bus.o_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_b got v=%b pc=%h imm=%h rdy=%b want 1 204 2 1", bus.o_valid, bus.o_pc, bus.o_imm, bus.o_ready);
        end
        $display("txn emit pc=%h imm=%h", bus.o_pc, bus.o_imm);
        @(negedge clk);
        bus.i_valid = 1'b0;
        n_checks++;
        if (bus.o_valid !== 1'b1 || bus.o_pc !== 32'h208 || bus.o_imm !== 32'd3) begin
            n_fail++; $display("FAIL b2b_c got v=%b pc=%h imm=%h want 1 208 3", bus.o_valid, bus.o_pc, bus.o_imm);
        end
        $display("txn emit pc=%h imm=%h", bus.o_pc, bus.o_imm);
        @(negedge clk);
        n_checks++;
        if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_dup got v=%b pc=%h want 0", bus.o_valid, bus.o_pc); end
    endtask

    task automatic fill_skid();
        bus.i_ready = 1'b0;
        drive_insn(32'h0010_0093, 32'h300);
        drive_insn(32'h0020_0093, 32'h304);
    endtask

    task automatic test_flush_skid();
        fill_skid();
        n_checks++;
        if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL fl_pre got rdy=%b want 0", bus.o_ready); end
        bus.i_flush = 1'b1;
        bus.i_valid = 1'b1; bus.i_instr = 32'h0090_0093; bus.i_pc = 32'h400;
        @(negedge clk);
        bus.i_flush = 1'b0; bus.i_valid = 1'b0; bus.i_ready = 1'b1;
        n_checks++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush got v=%b rdy=%b want 0 1", bus.o_valid, bus.o_ready);
        end
        $display("txn flush valid=%b ready=%b", bus.o_valid, bus.o_ready);
        @(negedge clk);
        n_checks++;
        if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop got v=%b pc=%h want 0", bus.o_valid, bus.o_pc); end
    endtask

    task automatic test_reset_skid();
        fill_skid();
        rst = 1'b1;
        bus.i_valid = 1'b1; bus.i_instr = 32'h0090_0093; bus.i_pc = 32'h500;
        @(negedge clk);
        rst = 1'b0; bus.i_valid = 1'b0; bus.i_ready = 1'b1;
        n_checks++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_pc !== PC_RST) begin
            n_fail++; $display("FAIL rst_skid got v=%b rdy=%b pc=%h want 0 1 %h", bus.o_valid, bus.o_ready, bus.o_pc, PC_RST);
        end
        $display("txn reset-in-skid valid=%b pc=%h", bus.o_valid, bus.o_pc);
        @(negedge clk);
        n_checks++;
        if (bus.o_valid !== 1'b0 || bus.o_imm !== 32'd0) begin
            n_fail++; $display("FAIL rst_replay got v=%b imm=%h want 0 0", bus.o_valid, bus.o_imm);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.i_flush = 1'b0; bus.i_valid = 1'b0; bus.i_ready = 1'b0;
        bus.i_instr = '0;   bus.i_pc = '0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_alu_imm();
        test_store();
        test_branch_lui();
        test_illegal();
        test_back_to_back();
        test_flush_skid();
        test_reset_skid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Registered RV32I/RV64I decode stage with a valid/ready handshake, sitting between fetch and execute in the pipelined successor to the single-cycle core.
- Classifies the opcode against the shared opcode set and extracts register indices and function fields.
- Generates an XLEN-wide sign-extended immediate.
- A 2-entry skid buffer absorbs execute-side backpressure without combinational ready paths.

Parameters:
- XLEN, 32, datapath width for pc and imm; legal values 32 or 64.
- PC_RESET, 0, reset value of o_pc (width XLEN).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_flush  in  1  discard all buffered entries
- i_valid  in  1  fetch presents instruction
- o_ready  out  1  stage can accept
- i_instr  in  32  raw instruction
- i_pc  in  XLEN  instruction address
- o_valid  out  1  decoded entry available
- i_ready  in  1  execute accepts
- o_pc  out  XLEN  pc of output entry
- o_itype  out  4  insn_class_t encoding
- o_rd, o_rs1, o_rs2  out  5 each  register indices
- o_funct3  out  3  funct3 field
- o_funct7b5  out  1  instr[30]
- o_imm  out  XLEN  sign-extended immediate
- Clock and reset: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (i_rst high at an edge): o_valid=0, o_ready=1, o_pc=PC_RESET, all other outputs 0. Reset mid-transfer drops both entries; nothing is replayed.
- Accept: i_valid && o_ready. Emit: o_valid && i_ready.
- Latency: an accepted instruction appears on o_* the next cycle when the stage is empty.
- o_ready is a register output: o_ready = !skid_valid.
- FSM:
  - EMPTY: accept -> FULL.
  - FULL: accept && !emit -> SKID (entry goes to skid register). Emit && !accept -> EMPTY. Accept && emit -> FULL (main register reloads).
  - SKID: emit -> FULL (skid moves to main). Acceptance is impossible in SKID.
- Order is strictly FIFO. Outputs are stable while o_valid && !i_ready.
- Flush: i_flush has priority over accept, emit and state. Next state is EMPTY, o_valid=0, o_ready=1. An instruction presented in the flush cycle is dropped.
- Decoding is done on the input side before registering (main and skid hold decoded fields).
- Class mapping by opcode:
  - 0110011 R
  - 0010011 I_ALU
  - 1100111 I_JALR
  - 0000011 I_LOAD
  - 1101111 J
  - 0100011 S
  - 1100011 B
  - 0110111 U_LUI
  - 0010111 U_AUIPC
  - anything else ILLEGAL
- Immediates, all sign-extended from instr[31] to XLEN:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - R and ILLEGAL: imm=0.
- Fields rd/rs1/rs2/funct3/funct7b5 are passed raw regardless of class.

Optional Feature:
- Macro: RV_DECODE_ILLEGAL_CHECK_EN.
- When defined:
  - Class is also ILLEGAL when instr[1:0] != 2'b11.
  - Class is also ILLEGAL for R type with funct7 not in {0000000, 0100000}.
  - Class is also ILLEGAL for I_JALR or I_LOAD funct3 values outside RV32I (JALR != 000; LOAD funct3 in {011, 110, 111}).
  - Output port o_illegal (1 bit) is added, equal to (o_itype == ILLEGAL). It resets to 0.
- When not defined: opcode-only classification and no o_illegal port.

Decomposition:
- Shared package: add typedef enum logic [3:0] insn_class_t alongside the existing opcode constants:
  - R=0, I_ALU=1, I_JALR=2, I_LOAD=3, J=4, S=5, B=6, U_LUI=7, U_AUIPC=8, ILLEGAL=15.
- Also add to the package: typedef struct packed decoded_t (itype, rd, rs1, rs2, funct3, funct7b5, imm) parametrised via XLEN localparam, or an explicit width.
- Sub-module: rv_imm_gen, a combinational immediate generator (instr, itype -> imm[XLEN-1:0]), reusable by the single-cycle core.

Test Plan:
- Single instruction: 0x00500093 @pc 0x100, i_ready=1 -> next cycle o_valid=1, itype=I_ALU, rd=1, rs1=0, imm=5, o_pc=0x100.
- Store 0xFE20AE23 (sw x2,-4(x1)) -> itype=S, rs1=1, rs2=2, funct3=010, imm=0xFFFFFFFC (XLEN=64: all-ones upper bits).
- Branch 0xFE000CE3 -> itype=B, imm=-8. LUI 0x123452B7 -> itype=U_LUI, rd=5, imm=0x12345000.
- Backpressure: back-to-back inputs A, B, C with i_ready held low for 3 cycles:
  - o_ready falls the cycle after B is accepted; C is held off.
  - After i_ready rises, outputs are A, B, C in order with no loss or duplication.
- Flush while in SKID with i_valid=1 -> next cycle o_valid=0, o_ready=1, the input instruction is not output; reset mid-SKID gives the same result with o_pc=PC_RESET.
- Opcode 0x7F -> ILLEGAL, imm=0. With RV_DECODE_ILLEGAL_CHECK_EN, instruction 0x00500090 (instr[1:0]=00) -> ILLEGAL and o_illegal=1.
